// File: rtl/mux41.sv
// Registered 4:1 multiplexer with select {s0,s1}.
// One-cycle latency; the applied select code is mirrored on sel_q.
module mux41 #(
    parameter int WIDTH = 1
) (
    output logic [WIDTH-1:0] op,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic             s0,
    input  logic             s1,
    input  logic             clk,
    input  logic             rst_n,
    output logic [1:0]       sel_q
);

    logic [1:0]       w_sel;
    logic [WIDTH-1:0] w_mux;
    logic [WIDTH-1:0] r_op;
    logic [1:0]       r_sel_q;

    assign w_sel = {s0, s1};

    // An X/Z select matches no item and yields all-X data.
    always_comb begin
        w_mux = 'x;
        case (w_sel)
            2'd0:    w_mux = in0;
            2'd1:    w_mux = in1;
            2'd2:    w_mux = in2;
            2'd3:    w_mux = in3;
            default: w_mux = 'x;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op    <= '0;
            r_sel_q <= 2'b00;
        end else begin
            r_op    <= w_mux;
            r_sel_q <= w_sel;
        end
    end

    assign op    = r_op;
    assign sel_q = r_sel_q;

endmodule

// File: tb/tb_mux41.sv
// Self-checking bench for mux41: vector table, corner sequences,
// and random stimulus against an array-indexing reference model.
module tb_mux41;

    logic       clk;
    logic       rst_n;
    logic       a_in0, a_in1, a_in2, a_in3;
    logic       a_s0, a_s1;
    logic       a_op;
    logic [1:0] a_selq;
    logic [7:0] b_in0, b_in1, b_in2, b_in3;
    logic       b_s0, b_s1;
    logic [7:0] b_op;
    logic [1:0] b_selq;

    int errors = 0;
    int checks = 0;

    mux41 #(.WIDTH(1)) u_w1 (
        .op(a_op), .in0(a_in0), .in1(a_in1), .in2(a_in2), .in3(a_in3),
        .s0(a_s0), .s1(a_s1), .clk(clk), .rst_n(rst_n), .sel_q(a_selq)
    );

    mux41 #(.WIDTH(8)) u_w8 (
        .op(b_op), .in0(b_in0), .in1(b_in1), .in2(b_in2), .in3(b_in3),
        .s0(b_s0), .s1(b_s1), .clk(clk), .rst_n(rst_n), .sel_q(b_selq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       s0;
        logic       s1;
        logic [3:0] ins;
        logic       exp_op;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic s0, input logic s1,
                           input logic [3:0] ins);
        a_s0  = s0;
        a_s1  = s1;
        a_in0 = ins[0];
        a_in1 = ins[1];
        a_in2 = ins[2];
        a_in3 = ins[3];
    endtask

    vec_t vecs[8];
    logic [3:0] rin;
    logic [7:0] bx[4];
    logic [1:0] rs;
    logic       exp_a;
    logic [7:0] exp_b;

    initial begin
        rst_n = 1'b0;
        drive_a(1'b1, 1'b1, 4'b1111);
        b_s0 = 1'b0; b_s1 = 1'b0;
        b_in0 = 8'h11; b_in1 = 8'h22; b_in2 = 8'h44; b_in3 = 8'h88;
        #1;
        chk("reset_op_immediate", {31'd0, a_op}, 32'd0);
        chk("reset_selq_immediate", {30'd0, a_selq}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("reset_op_hold", {31'd0, a_op}, 32'd0);
            chk("reset_selq_hold", {30'd0, a_selq}, 32'd0);
        end
        rst_n = 1'b1;
        step();
        chk("release_op", {31'd0, a_op}, 32'd1);
        chk("release_selq", {30'd0, a_selq}, 32'd3);

        // per-code walk: selected input 0 then 1, others held at 1/0 mix
        vecs[0] = '{1'b0, 1'b0, 4'b1110, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 4'b0001, 1'b1};
        vecs[2] = '{1'b0, 1'b1, 4'b1101, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 4'b0010, 1'b1};
        vecs[4] = '{1'b1, 1'b0, 4'b1011, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 4'b0100, 1'b1};
        vecs[6] = '{1'b1, 1'b1, 4'b0111, 1'b0};
        vecs[7] = '{1'b1, 1'b1, 4'b1000, 1'b1};
        for (int i = 0; i < 8; i++) begin
            drive_a(vecs[i].s0, vecs[i].s1, vecs[i].ins);
            step();
            chk($sformatf("walk_op_%0d", i), {31'd0, a_op},
                {31'd0, vecs[i].exp_op});
            chk($sformatf("walk_selq_%0d", i), {30'd0, a_selq},
                {30'd0, vecs[i].s0, vecs[i].s1});
        end

        // isolation: sel=2, in2=0, others toggle every cycle
        for (int i = 0; i < 6; i++) begin
            drive_a(1'b1, 1'b0, (i % 2 == 0) ? 4'b1011 : 4'b0000);
            step();
            chk("iso_op", {31'd0, a_op}, 32'd0);
            chk("iso_selq", {30'd0, a_selq}, 32'd2);
        end

        // latency: sel 0 -> 3 between edges, in0=0, in3=1
        drive_a(1'b0, 1'b0, 4'b1000);
        step();
        chk("lat_op_sel0", {31'd0, a_op}, 32'd0);
        #2;
        drive_a(1'b1, 1'b1, 4'b1000);
        #1;
        chk("lat_no_comb_path", {31'd0, a_op}, 32'd0);
        step();
        chk("lat_op_sel3", {31'd0, a_op}, 32'd1);
        chk("lat_selq", {30'd0, a_selq}, 32'd3);

        // async reset mid-run
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_op", {31'd0, a_op}, 32'd0);
        chk("async_selq", {30'd0, a_selq}, 32'd0);
        chk("async_op_w8", {24'd0, b_op}, 32'd0);
        step();
        chk("async_hold_op", {31'd0, a_op}, 32'd0);
        rst_n = 1'b1;
        step();
        chk("async_resume", {31'd0, a_op}, 32'd1);

        // WIDTH=8 select sweep
        for (int i = 0; i < 4; i++) begin
            rs = 2'(i);
            b_s0 = rs[1];
            b_s1 = rs[0];
            step();
            chk($sformatf("w8_op_%0d", i), {24'd0, b_op},
                {24'd0, 8'h11 << i});
            chk($sformatf("w8_selq_%0d", i), {30'd0, b_selq}, {30'd0, rs});
        end

        // random stimulus vs array-index model
        for (int n = 0; n < 300; n++) begin
            rin = 4'($urandom);
            rs  = 2'($urandom);
            drive_a(rs[1], rs[0], rin);
            exp_a = rin[{rs[1], rs[0]}];
            for (int k = 0; k < 4; k++) bx[k] = 8'($urandom);
            b_in0 = bx[0]; b_in1 = bx[1]; b_in2 = bx[2]; b_in3 = bx[3];
            rs = 2'($urandom);
            b_s0 = rs[1];
            b_s1 = rs[0];
            exp_b = bx[rs];
            step();
            chk("rand_op_w1", {31'd0, a_op}, {31'd0, exp_a});
            chk("rand_op_w8", {24'd0, b_op}, {24'd0, exp_b});
            chk("rand_selq_w8", {30'd0, b_selq}, {30'd0, rs});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mux41.md
MUX41 -- requirements
Module: mux41

Interface
REQ-001 Parameter: WIDTH, default 1, data width of each input and of op.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: op  output  WIDTH  registered mux output.
REQ-005 Port: in0  input  WIDTH  data input, selected by code 0.
REQ-006 Port: in1  input  WIDTH  data input, selected by code 1.
REQ-007 Port: in2  input  WIDTH  data input, selected by code 2.
REQ-008 Port: in3  input  WIDTH  data input, selected by code 3.
REQ-009 Port: s0  input  1  select MSB.
REQ-010 Port: s1  input  1  select LSB.
REQ-011 Port: sel_q  output  2  registered copy of {s0,s1} used for the current op value.
REQ-012 Positional port order SHALL be op, in0, in1, in2, in3, s0, s1, clk, rst_n, sel_q; instances in the codebase bind the first seven positionally.

Function
REQ-013 Select code SHALL be sel = {s0,s1} (s0 = bit 1, s1 = bit 0): 0 -> in0, 1 -> in1, 2 -> in2, 3 -> in3.
- Examples: s0=0,s1=1 -> in1; s0=1,s1=0 -> in2.
REQ-014 On every rising clk edge with rst_n high, op SHALL load the selected input and sel_q SHALL load {s0,s1}.
REQ-015 Latency SHALL be exactly one clock: op at edge N+1 reflects inputs and select sampled at edge N.
- No combinational path from inputs to op.
REQ-016 Unselected inputs SHALL have no effect on op, including when they toggle in the same cycle as the select change.
REQ-017 Select and data changing in the same cycle SHALL use the new select with the new data value.
REQ-018 X/Z on s0 or s1 SHALL NOT be treated as a legal code.
- op SHALL capture all-X in simulation.
- Synthesis result is don't-care.
REQ-019 No enable, no handshake: the register updates every cycle.
REQ-020 WIDTH SHALL be any value >= 1; the selection applies bitwise across the full width.

Reset
REQ-021 While rst_n = 0, op SHALL be 0 and sel_q SHALL be 2'b00, immediately and without waiting for clk.
REQ-022 Reset assertion mid-operation SHALL clear op and sel_q asynchronously, overriding any same-edge load.
REQ-023 On the first rising clk edge after rst_n deasserts, normal loading per REQ-014 SHALL resume.
- No extra idle cycle.

Verification
REQ-024 Reset: rst_n=0, all inputs 1, s0=s1=1, clock running -> op=0, sel_q=00 throughout; release rst_n -> op=1 one edge later.
REQ-025 Per-code walk, one step per 100-time-unit stimulus block, checked one clock after each stimulus change:
- s0=0,s1=0, in0 0->1 -> op 0 then 1.
- s0=0,s1=1, in1 0->1 -> op 0 then 1.
- s0=1,s1=0, in2 0->1 -> op 0 then 1.
- s0=1,s1=1, in3 0->1 -> op 0 then 1.
REQ-026 Isolation: sel={s0,s1}=2, in2=0, toggle in0, in1, in3 every cycle -> op stays 0; sel_q=10.
REQ-027 Latency: change sel 0->3 with in0=0, in3=1 between edges -> op=0 at the next edge, op=1 one edge later.
REQ-028 Async reset mid-run: op=1, assert rst_n low between clock edges -> op=0 before the next clk edge.
REQ-029 WIDTH=8 instance: in0..in3 = 8'h11, 8'h22, 8'h44, 8'h88; cycle sel through 0..3 -> op = 11, 22, 44, 88, each lagging one clock.
